// File: rtl/mesh_mon_pkg.sv
// Shared types and helpers for the mesh FIFO overflow monitor.
package mesh_mon_pkg;

    typedef enum logic {ARMED = 1'b0, CAPTURED = 1'b1} cap_state_t;

    // Widest event vector popcount accepts; callers zero-extend narrower vectors.
    localparam int MAX_CH = 1024;

    function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    // Adds and clamps to the largest value representable in w bits (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/fifo_ch_monitor.sv
// Per-channel overflow detector: event, pulse, sticky flag and high-water mark.
module fifo_ch_monitor
    import mesh_mon_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int CW         = 3,
    parameter int POP_RESCUE = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [CW-1:0] i_count,
    output logic          o_ev,
    output logic          o_pulse,
    output logic          o_sticky,
    output logic [CW-1:0] o_high_water
);

    logic          w_full;
    logic          w_rescue;
    logic          r_pulse;
    logic          r_sticky;
    logic [CW-1:0] r_hw;

    assign w_full   = (i_count == CW'(DEPTH));
    assign w_rescue = (POP_RESCUE != 0) && i_pop;
    assign o_ev     = i_en & i_push & w_full & ~w_rescue;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pulse  <= 1'b0;
            r_sticky <= 1'b0;
            r_hw     <= '0;
        end else begin
            r_pulse  <= o_ev;
            r_sticky <= o_ev | (r_sticky & ~i_clear);
            // Clear restarts tracking from the current sample rather than from zero.
            if (i_clear)
                r_hw <= i_en ? i_count : '0;
            else if (i_en && (i_count > r_hw))
                r_hw <= i_count;
        end
    end

    assign o_pulse      = r_pulse;
    assign o_sticky     = r_sticky;
    assign o_high_water = r_hw;

endmodule

// File: rtl/fifo_ovf_monitor.sv
// Overflow/occupancy monitor for the router-interface output FIFOs: per-channel
// flags plus a saturating global total and a first-overflow capture record.
module fifo_ovf_monitor
    import mesh_mon_pkg::*;
#(
    parameter  int NUM_CH     = 64,
    parameter  int pckg_sz    = 40,
    parameter  int fifo_depth = 4,
    parameter  int CNT_W      = 16,
    parameter  int POP_RESCUE = 1,
    localparam int CW         = $clog2(fifo_depth) + 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_en,
    input  logic                      i_clear,
    input  logic [NUM_CH-1:0]         i_push,
    input  logic [NUM_CH-1:0]         i_pop,
    input  logic [NUM_CH*CW-1:0]      i_count,
    input  logic [NUM_CH*pckg_sz-1:0] i_data,
    output logic [NUM_CH-1:0]         o_ovf_pulse,
    output logic [NUM_CH-1:0]         o_ovf_sticky,
    output logic [NUM_CH*CW-1:0]      o_high_water,
    output logic [CNT_W-1:0]          o_ovf_total,
    output logic                      o_cap_valid,
    output logic [CH_W-1:0]           o_cap_ch,
    output logic [pckg_sz-1:0]        o_cap_data,
    output logic [CNT_W-1:0]          o_cap_cycle
);

    logic [NUM_CH-1:0]  w_ev;
    logic [MAX_CH-1:0]  w_ev_ext;
    logic               w_any_ev;
    logic [CH_W-1:0]    w_sel_ch;

    logic [CNT_W-1:0]   r_total;
    logic [CNT_W-1:0]   r_cycle;
    cap_state_t         r_state, w_state_nxt;
    logic [CH_W-1:0]    r_cap_ch, w_cap_ch_nxt;
    logic [pckg_sz-1:0] r_cap_data, w_cap_data_nxt;
    logic [CNT_W-1:0]   r_cap_cycle, w_cap_cycle_nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fifo_ch_monitor #(
            .DEPTH      (fifo_depth),
            .CW         (CW),
            .POP_RESCUE (POP_RESCUE)
        ) u_ch (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .i_en         (i_en),
            .i_clear      (i_clear),
            .i_push       (i_push[g]),
            .i_pop        (i_pop[g]),
            .i_count      (i_count[g*CW +: CW]),
            .o_ev         (w_ev[g]),
            .o_pulse      (o_ovf_pulse[g]),
            .o_sticky     (o_ovf_sticky[g]),
            .o_high_water (o_high_water[g*CW +: CW])
        );
    end

    assign w_any_ev = |w_ev;

    always_comb begin
        w_ev_ext               = '0;
        w_ev_ext[NUM_CH-1:0]   = w_ev;
    end

    // Lowest-index event wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        w_sel_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_ev[i]) w_sel_ch = CH_W'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_total <= '0;
            r_cycle <= '0;
        end else begin
            r_total <= CNT_W'(sat_add(32'(i_clear ? '0 : r_total), popcount(w_ev_ext), CNT_W));
            r_cycle <= r_cycle + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ARMED;
            r_cap_ch    <= '0;
            r_cap_data  <= '0;
            r_cap_cycle <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cap_ch    <= w_cap_ch_nxt;
            r_cap_data  <= w_cap_data_nxt;
            r_cap_cycle <= w_cap_cycle_nxt;
        end
    end

    // Clear re-arms first, so an event in the clear cycle is captured immediately.
    always_comb begin
        w_state_nxt     = r_state;
        w_cap_ch_nxt    = r_cap_ch;
        w_cap_data_nxt  = r_cap_data;
        w_cap_cycle_nxt = r_cap_cycle;
        if (i_clear) begin
            w_state_nxt     = ARMED;
            w_cap_ch_nxt    = '0;
            w_cap_data_nxt  = '0;
            w_cap_cycle_nxt = '0;
        end
        if ((i_clear || (r_state == ARMED)) && w_any_ev) begin
            w_state_nxt     = CAPTURED;
            w_cap_ch_nxt    = w_sel_ch;
            w_cap_data_nxt  = i_data[w_sel_ch*pckg_sz +: pckg_sz];
            w_cap_cycle_nxt = r_cycle;
        end
    end

    assign o_ovf_total = r_total;
    assign o_cap_valid = (r_state == CAPTURED);
    assign o_cap_ch    = r_cap_ch;
    assign o_cap_data  = r_cap_data;
    assign o_cap_cycle = r_cap_cycle;

endmodule

// File: tb/tb_fifo_ovf_monitor.sv
// Scoreboard bench for fifo_ovf_monitor: default config plus POP_RESCUE=0 and CNT_W=4 variants.
module tb_fifo_ovf_monitor;

    localparam int NC  = 64;
    localparam int PW  = 40;
    localparam int CW  = 3;
    localparam int CHW = 6;

    logic            clk = 1'b0;
    logic            reset, en, clear;
    logic [NC-1:0]   push, pop;
    logic [NC*CW-1:0] count;
    logic [NC*PW-1:0] data;

    logic [NC-1:0] pulse0, sticky0, pulse1, sticky1, pulse2, sticky2;
    logic [NC*CW-1:0] hw0, hw1, hw2;
    logic [15:0] total0, total1, capcyc0, capcyc1;
    logic [3:0]  total2, capcyc2;
    logic        capv0, capv1, capv2;
    logic [CHW-1:0] capch0, capch1, capch2;
    logic [PW-1:0]  capdata0, capdata1, capdata2;

    always #5 clk = ~clk;

    fifo_ovf_monitor #(.NUM_CH(NC), .pckg_sz(PW), .fifo_depth(4), .CNT_W(16), .POP_RESCUE(1)) d0 (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_clear(clear), .i_push(push), .i_pop(pop),
        .i_count(count), .i_data(data), .o_ovf_pulse(pulse0), .o_ovf_sticky(sticky0),
        .o_high_water(hw0), .o_ovf_total(total0), .o_cap_valid(capv0), .o_cap_ch(capch0),
        .o_cap_data(capdata0), .o_cap_cycle(capcyc0));

    fifo_ovf_monitor #(.NUM_CH(NC), .pckg_sz(PW), .fifo_depth(4), .CNT_W(16), .POP_RESCUE(0)) d1 (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_clear(clear), .i_push(push), .i_pop(pop),
        .i_count(count), .i_data(data), .o_ovf_pulse(pulse1), .o_ovf_sticky(sticky1),
        .o_high_water(hw1), .o_ovf_total(total1), .o_cap_valid(capv1), .o_cap_ch(capch1),
        .o_cap_data(capdata1), .o_cap_cycle(capcyc1));

    fifo_ovf_monitor #(.NUM_CH(NC), .pckg_sz(PW), .fifo_depth(4), .CNT_W(4), .POP_RESCUE(1)) d2 (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_clear(clear), .i_push(push), .i_pop(pop),
        .i_count(count), .i_data(data), .o_ovf_pulse(pulse2), .o_ovf_sticky(sticky2),
        .o_high_water(hw2), .o_ovf_total(total2), .o_cap_valid(capv2), .o_cap_ch(capch2),
        .o_cap_data(capdata2), .o_cap_cycle(capcyc2));

    typedef enum int {S_PULSE, S_STICKY, S_TOTAL, S_TOT_NR, S_TOT_C4, S_CAPV, S_CAPCH,
                      S_CAPDATA, S_CAPCYC, S_HW, S_HWALL} sel_t;
    typedef struct {
        string        tag;
        sel_t         sel;
        int           idx;
        logic [255:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] obs(input sel_t s, input int idx);
        case (s)
            S_PULSE:   return 256'(pulse0);
            S_STICKY:  return 256'(sticky0);
            S_TOTAL:   return 256'(total0);
            S_TOT_NR:  return 256'(total1);
            S_TOT_C4:  return 256'(total2);
            S_CAPV:    return 256'(capv0);
            S_CAPCH:   return 256'(capch0);
            S_CAPDATA: return 256'(capdata0);
            S_CAPCYC:  return 256'(capcyc0);
            S_HW:      return 256'(hw0[idx*CW +: CW]);
            default:   return 256'(hw0);
        endcase
    endfunction

    task automatic expect_(input string tag, input sel_t s, input int idx, input logic [255:0] e);
        exp_t x;
        x.tag = tag; x.sel = s; x.idx = idx; x.exp = e;
        sb.push_back(x);
    endtask

    // One clock: cyc tracks the DUT's cycle counter value for the next cycle.
    task automatic step();
        exp_t e;
        @(posedge clk);
        if (reset) cyc = 0;
        else       cyc++;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel, e.idx), e.exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; en = 1'b1; clear = 1'b0;
        push = '0; pop = '0; count = '0; data = '0;
    endtask

    task automatic set_ch(input int ch, input int cnt, input logic psh, input logic [PW-1:0] d);
        count[ch*CW +: CW] = CW'(cnt);
        push[ch]           = psh;
        data[ch*PW +: PW]  = d;
    endtask

    function automatic logic [255:0] bit_(input int i);
        return 256'(1) << i;
    endfunction

    initial begin
        idle();
        reset = 1'b1;

        // Reset with random probes.
        for (int i = 0; i < 3; i++) begin
            reset = 1'b1;
            en    = 1'($urandom);
            clear = 1'($urandom);
            push  = {$urandom, $urandom};
            pop   = {$urandom, $urandom};
            for (int c = 0; c < NC; c++) set_ch(c, $urandom_range(0, 7), push[c], {$urandom, $urandom});
            if (i == 2) begin
                expect_("rst_pulse", S_PULSE, 0, 0);
                expect_("rst_sticky", S_STICKY, 0, 0);
                expect_("rst_total", S_TOTAL, 0, 0);
                expect_("rst_tot_c4", S_TOT_C4, 0, 0);
                expect_("rst_capv", S_CAPV, 0, 0);
                expect_("rst_capch", S_CAPCH, 0, 0);
                expect_("rst_capdata", S_CAPDATA, 0, 0);
                expect_("rst_capcyc", S_CAPCYC, 0, 0);
                expect_("rst_hw", S_HWALL, 0, 0);
            end
            step();
        end

        // First overflow on ch5 in counter cycle 0.
        idle(); set_ch(5, 4, 1'b1, 40'h55);
        expect_("t1_pulse", S_PULSE, 0, bit_(5));
        expect_("t1_sticky", S_STICKY, 0, bit_(5));
        expect_("t1_total", S_TOTAL, 0, 1);
        expect_("t1_capv", S_CAPV, 0, 1);
        expect_("t1_capch", S_CAPCH, 0, 5);
        expect_("t1_capdata", S_CAPDATA, 0, 40'h55);
        expect_("t1_capcyc", S_CAPCYC, 0, 0);
        expect_("t1_hw5", S_HW, 5, 4);
        step();
        idle();
        expect_("t1_pulse_off", S_PULSE, 0, 0);
        expect_("t1_sticky_hold", S_STICKY, 0, bit_(5));
        step();

        // Push+pop on a full FIFO: rescued only when POP_RESCUE=1.
        idle(); set_ch(9, 4, 1'b1, 0); pop[9] = 1'b1;
        expect_("t2_pulse", S_PULSE, 0, 0);
        expect_("t2_total", S_TOTAL, 0, 1);
        expect_("t2_total_nr", S_TOT_NR, 0, 2);
        step();

        idle(); clear = 1'b1;
        expect_("clr_sticky", S_STICKY, 0, 0);
        expect_("clr_total", S_TOTAL, 0, 0);
        expect_("clr_total_nr", S_TOT_NR, 0, 0);
        expect_("clr_tot_c4", S_TOT_C4, 0, 0);
        expect_("clr_capv", S_CAPV, 0, 0);
        expect_("clr_capch", S_CAPCH, 0, 0);
        expect_("clr_capcyc", S_CAPCYC, 0, 0);
        expect_("clr_hw5", S_HW, 5, 0);
        step();

        idle();
        for (int k = 0; k < 40 && cyc != 17; k++) step();
        chk("t3_cyc_reached", 256'(cyc), 256'(17));

        // Simultaneous events; lowest channel captured.
        idle(); set_ch(3, 4, 1'b1, 40'hAB); set_ch(40, 4, 1'b1, 40'hCD);
        expect_("t3_pulse", S_PULSE, 0, bit_(3) | bit_(40));
        expect_("t3_total", S_TOTAL, 0, 2);
        expect_("t3_capch", S_CAPCH, 0, 3);
        expect_("t3_capdata", S_CAPDATA, 0, 40'hAB);
        expect_("t3_capcyc", S_CAPCYC, 0, 17);
        step();
        idle(); set_ch(1, 4, 1'b1, 40'h11);
        expect_("t3_pulse_ch1", S_PULSE, 0, bit_(1));
        expect_("t3_sticky", S_STICKY, 0, bit_(1) | bit_(3) | bit_(40));
        expect_("t3_total2", S_TOTAL, 0, 3);
        expect_("t3_capch_hold", S_CAPCH, 0, 3);
        expect_("t3_capdata_hold", S_CAPDATA, 0, 40'hAB);
        expect_("t3_capcyc_hold", S_CAPCYC, 0, 17);
        step();

        // Saturation on the 4-bit counter variant.
        idle(); for (int c = 10; c <= 21; c++) set_ch(c, 4, 1'b1, 0);
        expect_("t4_total", S_TOTAL, 0, 15);
        expect_("t4_tot_c4", S_TOT_C4, 0, 15);
        expect_("t4_total_nr", S_TOT_NR, 0, 15);
        step();
        idle(); for (int c = 0; c <= 2; c++) set_ch(c, 4, 1'b1, 0);
        expect_("t4_pulse", S_PULSE, 0, 256'h7);
        expect_("t4_total_b", S_TOTAL, 0, 18);
        expect_("t4_tot_c4_sat", S_TOT_C4, 0, 15);
        step();
        idle(); set_ch(0, 4, 1'b1, 0);
        expect_("t4_pulse_b2b", S_PULSE, 0, bit_(0));
        expect_("t4_total_c", S_TOTAL, 0, 19);
        expect_("t4_tot_c4_hold", S_TOT_C4, 0, 15);
        step();

        // Clear coinciding with a ch7 event.
        idle(); clear = 1'b1;
        set_ch(7, 4, 1'b1, 40'h77); set_ch(20, 2, 1'b0, 0); set_ch(30, 3, 1'b0, 0);
        expect_("t5_sticky", S_STICKY, 0, bit_(7));
        expect_("t5_pulse", S_PULSE, 0, bit_(7));
        expect_("t5_total", S_TOTAL, 0, 1);
        expect_("t5_tot_c4", S_TOT_C4, 0, 1);
        expect_("t5_capv", S_CAPV, 0, 1);
        expect_("t5_capch", S_CAPCH, 0, 7);
        expect_("t5_capdata", S_CAPDATA, 0, 40'h77);
        expect_("t5_capcyc", S_CAPCYC, 0, 256'(cyc));
        expect_("t5_hw20", S_HW, 20, 2);
        expect_("t5_hw30", S_HW, 30, 3);
        expect_("t5_hw7", S_HW, 7, 4);
        expect_("t5_hw10", S_HW, 10, 0);
        step();

        // en=0 freezes recording.
        for (int v = 0; v <= 4; v++) begin
            idle(); en = 1'b0; set_ch(2, v, 1'b1, 0);
            expect_("t6_pulse_off", S_PULSE, 0, 0);
            expect_("t6_hw2_frozen", S_HW, 2, 0);
            expect_("t6_total_hold", S_TOTAL, 0, 1);
            step();
        end
        idle(); set_ch(2, 3, 1'b1, 0);
        expect_("t6_hw2_resume", S_HW, 2, 3);
        expect_("t6_pulse_nf", S_PULSE, 0, 0);
        step();
        idle(); set_ch(2, 4, 1'b1, 40'h22);
        expect_("t6_pulse", S_PULSE, 0, bit_(2));
        expect_("t6_hw2_full", S_HW, 2, 4);
        expect_("t6_total", S_TOTAL, 0, 2);
        expect_("t6_sticky", S_STICKY, 0, bit_(2) | bit_(7));
        expect_("t6_capch_hold", S_CAPCH, 0, 7);
        step();
        idle(); set_ch(2, 6, 1'b1, 0);
        expect_("t6_over_pulse", S_PULSE, 0, 0);
        expect_("t6_hw2_over", S_HW, 2, 6);
        step();
        idle(); en = 1'b0; clear = 1'b1; set_ch(2, 5, 1'b1, 0);
        expect_("t6_clr_en0_hw2", S_HW, 2, 0);
        expect_("t6_clr_en0_sticky", S_STICKY, 0, 0);
        expect_("t6_clr_en0_total", S_TOTAL, 0, 0);
        expect_("t6_clr_en0_capv", S_CAPV, 0, 0);
        step();

        // Reset mid-operation overrides a same-cycle event.
        idle(); set_ch(6, 4, 1'b1, 0);
        expect_("t7_sticky", S_STICKY, 0, bit_(6));
        step();
        idle(); reset = 1'b1; set_ch(4, 4, 1'b1, 0);
        expect_("t7_rst_pulse", S_PULSE, 0, 0);
        expect_("t7_rst_sticky", S_STICKY, 0, 0);
        expect_("t7_rst_total", S_TOTAL, 0, 0);
        expect_("t7_rst_capv", S_CAPV, 0, 0);
        expect_("t7_rst_hw", S_HWALL, 0, 0);
        step();
        idle();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
